unified_mem_arbiter: RTL and testbench

- Sequences one shared single-port RAM between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Grants one requester at a time and issues the RAM access.
- Counts the fixed RAM read latency and returns data with a one-cycle ready pulse.
- Drives pipe_stall so the hazard logic freezes the pipeline registers while any access is outstanding.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/unified_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mips_mem_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Grant register encodings
    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Default RAM read latency (cycles from ram_en to valid ram_rdata)
    localparam int DEF_MEM_LATENCY = 2;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port RAM between the IF and MEM pipeline stages.
// MEM has priority over IF. Reads wait MEM_LATENCY cycles for RAM data,
// writes complete in one cycle; each access ends with a one-cycle ready pulse.
// Optional anti-starvation guard for IF: define ARB_STARVE_GUARD_EN.
//
// Handshake: a requester raises its request (if_req, or mem_rd/mem_wr) and
// holds it with stable address/data until its ready pulses for one cycle.
// The arbiter samples address/data only in the grant cycle; if the request
// is dropped afterwards (flush) the access still completes and ready pulses.
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pipe_stall,
    output logic              busy
);

    // Counter holds MEM_LATENCY-1, at most 7
    localparam int CNT_W = 3;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 8 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("unified_mem_arbiter: MEM_LATENCY must be 1..8 and STARVE_LIMIT >= 1");
    end

    arb_state_e        state_q;
    logic              gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;

    logic mem_req;
    logic start;
    logic gnt_d;
    logic we_d;
    logic if_forced;

    assign mem_req = mem_rd | mem_wr;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q;

    assign if_forced = if_req && (starve_q == SW'(STARVE_LIMIT));

    // Count MEM grants that overtook a waiting fetch; clear once IF is served or stops asking
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (!if_req) begin
            starve_q <= '0;
        end else if (start) begin
            starve_q <= (gnt_d == GNT_MEM) ? starve_q + SW'(1) : '0;
        end
    end
`else
    assign if_forced = 1'b0;
`endif

    // Arbitrate in IDLE and drive the single RAM strobe for the winner in the same cycle
    always_comb begin
        start     = reset && (state_q == IDLE) && (if_req || mem_req);
        gnt_d     = (mem_req && !if_forced) ? GNT_MEM : GNT_IF;
        we_d      = (gnt_d == GNT_MEM) && mem_wr;
        ram_en    = start;
        ram_we    = start && we_d;
        ram_addr  = '0;
        ram_wdata = '0;
        if (start) begin
            ram_addr = (gnt_d == GNT_MEM) ? mem_addr : if_addr;
            if (we_d) begin
                ram_wdata = mem_wdata;
            end
        end
    end

    // Sequencing FSM: grant, count read latency, capture data, pulse ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            cnt_q       <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        gnt_q <= gnt_d;
                        if (we_d) begin
                            state_q     <= RESP;
                            mem_ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        if (gnt_q == GNT_MEM) begin
                            mem_rdata_q <= ram_rdata;
                            mem_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= ram_rdata;
                            if_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign busy       = (state_q != IDLE);
    assign pipe_stall = reset && ((if_req && !if_ready_q) || (mem_req && !mem_ready_q));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters checked every cycle against a
// transaction-level model (grant cycle, completion cycle, RAM contents).
module tb_unified_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int LIMIT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          pipe_stall;
    logic          busy;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pipe_stall(pipe_stall), .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = -1;
    bit     chk_en = 1'b0;

    // Inputs to apply at the next cycle
    logic          n_reset, n_if_req, n_mem_rd, n_mem_wr;
    logic [AW-1:0] n_if_addr, n_mem_addr;
    logic [DW-1:0] n_mem_wdata;

    // Behavioural model: RAM contents plus the one outstanding transaction
    logic [DW-1:0] ram_m [bit [AW-1:0]];
    bit            txn_v = 1'b0;
    longint        txn_g, txn_rdy;
    bit            txn_mem, txn_we;
    logic [DW-1:0] txn_data;
    bit            prev_rst_low = 1'b1;
    int            starve = 0;

    // Expected DUT outputs for the current cycle
    logic          e_ram_en, e_ram_we, e_if_ready, e_mem_ready, e_busy, e_stall;
    logic [AW-1:0] e_ram_addr;
    logic [DW-1:0] e_ram_wdata;
    logic [DW-1:0] e_if_rdata = '0;
    logic [DW-1:0] e_mem_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle: apply inputs, act as the RAM, predict outputs
    task automatic step();
        bit            take_mem;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        cyc++;
        reset     = n_reset;
        if_req    = n_if_req;
        if_addr   = n_if_addr;
        mem_rd    = n_mem_rd;
        mem_wr    = n_mem_wr;
        mem_addr  = n_mem_addr;
        mem_wdata = n_mem_wdata;

        if (prev_rst_low) begin
            txn_v       = 1'b0;
            e_if_rdata  = '0;
            e_mem_rdata = '0;
            starve      = 0;
        end

        e_if_ready  = txn_v && (cyc == txn_rdy) && !txn_mem;
        e_mem_ready = txn_v && (cyc == txn_rdy) && txn_mem;
        if (e_if_ready && !txn_we)  e_if_rdata  = txn_data;
        if (e_mem_ready && !txn_we) e_mem_rdata = txn_data;
        e_busy = txn_v && (cyc > txn_g) && (cyc <= txn_rdy);

        ram_rdata = (txn_v && !txn_we && cyc == txn_g + LAT) ? txn_data : DW'($urandom);

        e_ram_en = 1'b0; e_ram_we = 1'b0; e_ram_addr = '0; e_ram_wdata = '0;
        if (reset && !(txn_v && cyc <= txn_rdy) && (if_req || mem_rd || mem_wr)) begin
            take_mem = mem_rd || mem_wr;
`ifdef ARB_STARVE_GUARD_EN
            if (if_req && starve == LIMIT) take_mem = 1'b0;
            if (if_req) starve = take_mem ? starve + 1 : 0;
`endif
            a        = take_mem ? mem_addr : if_addr;
            txn_v    = 1'b1;
            txn_g    = cyc;
            txn_mem  = take_mem;
            txn_we   = take_mem && mem_wr;
            txn_rdy  = cyc + (txn_we ? 1 : LAT + 1);
            e_ram_en = 1'b1; e_ram_addr = a; e_ram_we = txn_we;
            if (txn_we) begin
                e_ram_wdata = mem_wdata;
                ram_m[a]    = mem_wdata;
            end else begin
                if (!ram_m.exists(a)) ram_m[a] = DW'($urandom);
                txn_data = ram_m[a];
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        if (!if_req) starve = 0;
`endif
        e_stall = reset && ((if_req && !e_if_ready) || ((mem_rd || mem_wr) && !e_mem_ready));
        prev_rst_low = !reset;
    endtask

    // Compare every output against the model in the middle of each cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_en", ram_en, e_ram_en);
            if (e_ram_en) begin
                chk("ram_addr", ram_addr, e_ram_addr);
                chk("ram_we", ram_we, e_ram_we);
                if (e_ram_we) chk("ram_wdata", ram_wdata, e_ram_wdata);
            end
            chk("if_ready", if_ready, e_if_ready);
            chk("mem_ready", mem_ready, e_mem_ready);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("mem_rdata", mem_rdata, e_mem_rdata);
            chk("busy", busy, e_busy);
            chk("pipe_stall", pipe_stall, e_stall);
        end
    end

    task automatic idle_inputs();
        n_if_req = 0; n_mem_rd = 0; n_mem_wr = 0;
        n_if_addr = '0; n_mem_addr = '0; n_mem_wdata = '0;
    endtask

    initial begin
        reset = 0; if_req = 1; if_addr = 32'h4; mem_rd = 0; mem_wr = 0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
        idle_inputs();

        // Reset held two cycles with a pending fetch
        n_reset = 0; n_if_req = 1; n_if_addr = 32'h4;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_en = 1'b1;
            #1;
            chk("rst_ram_en", ram_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_stall", pipe_stall, 0);
            chk("rst_if_ready", if_ready, 0);
            chk("rst_if_rdata", if_rdata, 0);
        end

        // Single fetch, latency 2
        ram_m[32'h4] = 32'h2008_0005;
        n_reset = 1;
        step(); #1;
        chk("fetch_ram_en", ram_en, 1);
        chk("fetch_ram_addr", ram_addr, 32'h4);
        chk("fetch_stall_t0", pipe_stall, 1);
        step(); #1; chk("fetch_stall_t1", pipe_stall, 1);
        step(); #1; chk("fetch_stall_t2", pipe_stall, 1);
        step(); #1;
        chk("fetch_if_ready", if_ready, 1);
        chk("fetch_if_rdata", if_rdata, 32'h2008_0005);
        chk("fetch_stall_t3", pipe_stall, 0);
        n_if_req = 0;
        step();

        // Simultaneous requests: MEM first, then IF
        n_mem_rd = 1; n_mem_addr = 32'h100; n_if_req = 1; n_if_addr = 32'h8;
        step(); #1;
        chk("sim_ram_addr_mem", ram_addr, 32'h100);
        step(); step();
        step(); #1; chk("sim_mem_ready", mem_ready, 1);
        n_mem_rd = 0;
        step(); #1;
        chk("sim_if_ram_en", ram_en, 1);
        chk("sim_ram_addr_if", ram_addr, 32'h8);
        step(); step();
        step(); #1; chk("sim_if_ready", if_ready, 1);
        n_if_req = 0;
        step();

        // Store then load
        n_mem_wr = 1; n_mem_addr = 32'h40; n_mem_wdata = 32'hDEAD_BEEF;
        step(); #1;
        chk("st_ram_we", ram_we, 1);
        chk("st_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        step(); #1; chk("st_mem_ready", mem_ready, 1);
        n_mem_wr = 0; n_mem_rd = 1;
        step(); #1;
        chk("ld_ram_en", ram_en, 1);
        chk("ld_ram_we", ram_we, 0);
        step(); step();
        step(); #1;
        chk("ld_mem_ready", mem_ready, 1);
        chk("ld_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        n_mem_rd = 0;
        step();

        // Reset in the middle of a read
        n_mem_rd = 1; n_mem_addr = 32'h80;
        step(); #1; chk("rmr_ram_en", ram_en, 1);
        n_reset = 0; n_mem_rd = 0;
        step();
        n_reset = 1;
        step(); #1;
        chk("rmr_busy", busy, 0);
        chk("rmr_ram_en", ram_en, 0);
        chk("rmr_mem_rdata", mem_rdata, 0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("rmr_no_ready", mem_ready, 0);
        end

        // Continuous MEM reads with a waiting fetch
        n_mem_rd = 1; n_mem_addr = 32'h200; n_if_req = 1; n_if_addr = 32'hC;
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("stv_ram_en", ram_en, 1);
`ifdef ARB_STARVE_GUARD_EN
            chk("stv_ram_addr", ram_addr, (k == 2) ? 32'hC : 32'h200);
`else
            chk("stv_ram_addr", ram_addr, 32'h200);
`endif
            step(); step(); step();
        end
        n_mem_rd = 0;
        step(); #1;
        chk("stv_if_after_drop", ram_addr, 32'hC);
        n_if_req = 0;
        for (int i = 0; i < 6; i++) step();

        // Randomized requesters with flushes and occasional reset
        for (int i = 0; i < 4000; i++) begin
            n_reset = ($urandom_range(0, 149) != 0);
            if (n_if_req) begin
                if (e_if_ready || $urandom_range(0, 19) == 0) n_if_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                n_if_req  = 1;
                n_if_addr = AW'($urandom_range(0, 15) * 4);
            end
            if (n_mem_rd || n_mem_wr) begin
                if (e_mem_ready || $urandom_range(0, 19) == 0) begin
                    n_mem_rd = 0; n_mem_wr = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: begin n_mem_rd = 1; n_mem_wr = 0; end
                    4, 5, 6:    begin n_mem_rd = 0; n_mem_wr = 1; end
                    default:    begin n_mem_rd = 1; n_mem_wr = 1; end
                endcase
                n_mem_addr  = AW'($urandom_range(0, 15) * 4);
                n_mem_wdata = DW'($urandom);
            end
            step();
        end

        idle_inputs();
        n_reset = 1;
        for (int i = 0; i < 8; i++) step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
